// File: rtl/multiport_regfile_commit_pkg.sv
// Shared types and constants for the multiport commit/regfile block.
// Contents:
//   ID_W, id_t          instruction ID carried with every writeback result
//   REG_AW              architectural register address width
//   DEF_* constants     default sizing shared by the top and its interface
//   sel_width()         index width for a one-of-n select, never below 1 bit
package multiport_regfile_commit_pkg;

    localparam int ID_W             = 4;
    localparam int REG_AW           = 5;
    localparam int DEF_XLEN         = 32;
    localparam int DEF_NUM_WB_UNITS = 4;

    typedef logic [ID_W-1:0] id_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiport_regfile_commit_if.sv
// Writeback-unit handshake bundle between the writeback units and the commit block.
// Signals:
//   unit_done  [N]         unit holds a valid result (held until acked)
//   unit_id    [N] id_t    instruction ID of the held result
//   unit_data  [N][XLEN]   result data
//   unit_ack   [N]         result accepted this cycle (zero-latency)
//   alu_issued             single-cycle ALU (unit 0) result valid this cycle
// Modports: master = writeback units side, slave = commit block side.
interface multiport_regfile_commit_if
    import multiport_regfile_commit_pkg::*;
#(
    parameter int NUM_WB_UNITS = DEF_NUM_WB_UNITS,
    parameter int XLEN         = DEF_XLEN
);

    logic [NUM_WB_UNITS-1:0]           unit_done;
    id_t  [NUM_WB_UNITS-1:0]           unit_id;
    logic [NUM_WB_UNITS-1:0][XLEN-1:0] unit_data;
    logic [NUM_WB_UNITS-1:0]           unit_ack;
    logic                              alu_issued;

    modport master (
        output unit_done,
        output unit_id,
        output unit_data,
        output alu_issued,
        input  unit_ack
    );

    modport slave (
        input  unit_done,
        input  unit_id,
        input  unit_data,
        input  alu_issued,
        output unit_ack
    );

endinterface

// File: rtl/multiport_regfile_commit_bank.sv
// One register-file bank: a single write port and READ_PORTS combinational read ports.
// Contents are intentionally not reset; the live-value table decides which bank
// holds the current value of each register, so stale bank contents are never selected.
// Ports:
//   clk     clock
//   we      write enable (commit update for this bank's port)
//   waddr   write register address
//   wdata   write data
//   raddr   [READ_PORTS] read addresses
//   rdata   [READ_PORTS] read data, combinational
module regfile_bank
    import multiport_regfile_commit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int READ_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [REG_AW-1:0]                   waddr,
    input  logic [XLEN-1:0]                     wdata,
    input  logic [READ_PORTS-1:0][REG_AW-1:0]   raddr,
    output logic [READ_PORTS-1:0][XLEN-1:0]     rdata
);

    logic [XLEN-1:0] mem_r [NUM_REGS];

    // Storage write on commit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Asynchronous read ports.
    always_comb begin
        rdata = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            rdata[r] = mem_r[raddr[r]];
        end
    end

endmodule

// File: rtl/multiport_regfile_commit.sv
// Commit stage and LVT-banked register file.
// Round-robin arbitrates NUM_WB_UNITS writeback units onto COMMIT_PORTS commit ports,
// commits the newest write per register into one bank per port, steers reads through a
// live-value table, and forwards retiring data to a waiting store by instruction ID.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   wb               writeback handshake (slave side): done/id/data in, ack out, alu_issued
//   ids_retiring     [W] ID on each commit port        retired [W] port carries a result
//   rd_addr          [W] dest reg of ids_retiring      id_for_rd [W] newest ID issued to rd_addr
//   rs_addr/rs_data  [R] combinational read ports
//   st_waiting/st_id/st_ack in, st_done/st_data out: store-forward capture
module multiport_regfile_commit
    import multiport_regfile_commit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_WB_UNITS = 4,
    parameter int COMMIT_PORTS = 2,
    parameter int READ_PORTS   = 2,
    parameter bit FIXED_PORT0  = 1'b1,
    parameter bit BYPASS       = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    multiport_regfile_commit_if.slave           wb,
    output id_t  [COMMIT_PORTS-1:0]             ids_retiring,
    output logic [COMMIT_PORTS-1:0]             retired,
    input  logic [COMMIT_PORTS-1:0][REG_AW-1:0] rd_addr,
    input  id_t  [COMMIT_PORTS-1:0]             id_for_rd,
    input  logic [READ_PORTS-1:0][REG_AW-1:0]   rs_addr,
    output logic [READ_PORTS-1:0][XLEN-1:0]     rs_data,
    input  logic                                st_waiting,
    input  id_t                                 st_id,
    input  logic                                st_ack,
    output logic                                st_done,
    output logic [XLEN-1:0]                     st_data
);

    localparam int UNIT_W = sel_width(NUM_WB_UNITS);
    localparam int LVT_W  = sel_width(COMMIT_PORTS);

    logic [UNIT_W-1:0]                          rr_ptr_r;
    logic [LVT_W-1:0]                           lvt_r [NUM_REGS];
    logic                                       st_done_r;
    logic [XLEN-1:0]                            st_data_r;

    logic [NUM_WB_UNITS-1:0]                    ack_s;
    logic [COMMIT_PORTS-1:0]                    retired_s;
    id_t  [COMMIT_PORTS-1:0]                    ids_s;
    logic [COMMIT_PORTS-1:0][XLEN-1:0]          cdata_s;
    logic                                       grant_any_s;
    logic [UNIT_W-1:0]                          last_unit_s;
    logic [UNIT_W-1:0]                          next_ptr_s;
    logic [COMMIT_PORTS-1:0]                    update_s;
    logic [COMMIT_PORTS-1:0][READ_PORTS-1:0][XLEN-1:0] bank_rd_s;
    logic [READ_PORTS-1:0][XLEN-1:0]            rs_data_s;
    logic                                       st_match_s;
    logic [XLEN-1:0]                            st_cap_s;

    // Port arbitration: each free port in ascending order takes the first done,
    // not-yet-granted unit found walking from rr_ptr around the ring. Everything is
    // held at zero while reset is asserted.
    always_comb begin
        logic [UNIT_W:0]   sum_v;
        logic [UNIT_W-1:0] cand_v;
        logic              found_v;
        ack_s       = '0;
        retired_s   = '0;
        ids_s       = '0;
        cdata_s     = '0;
        grant_any_s = 1'b0;
        last_unit_s = '0;
        sum_v       = '0;
        cand_v      = '0;
        found_v     = 1'b0;
        if (rst) begin
            for (int p = 0; p < COMMIT_PORTS; p++) begin
                if (FIXED_PORT0 && (p == 0)) begin
                    // Port 0 belongs to the single-cycle ALU; no arbitration.
                    if (wb.alu_issued) begin
                        retired_s[0] = 1'b1;
                        ack_s[0]     = 1'b1;
                        ids_s[0]     = wb.unit_id[0];
                        cdata_s[0]   = wb.unit_data[0];
                    end else begin
                        retired_s[0] = 1'b0;
                    end
                end else begin
                    found_v = 1'b0;
                    for (int k = 0; k < NUM_WB_UNITS; k++) begin
                        sum_v = {1'b0, rr_ptr_r} + (UNIT_W+1)'(k);
                        if (sum_v >= (UNIT_W+1)'(NUM_WB_UNITS)) begin
                            sum_v = sum_v - (UNIT_W+1)'(NUM_WB_UNITS);
                        end else begin
                            sum_v = sum_v;
                        end
                        cand_v = sum_v[UNIT_W-1:0];
                        // ack_s doubles as the "already granted this cycle" mask.
                        if (!found_v && wb.unit_done[cand_v] && !ack_s[cand_v]
                            && !(FIXED_PORT0 && (cand_v == '0))) begin
                            found_v       = 1'b1;
                            ack_s[cand_v] = 1'b1;
                            retired_s[p]  = 1'b1;
                            ids_s[p]      = wb.unit_id[cand_v];
                            cdata_s[p]    = wb.unit_data[cand_v];
                            grant_any_s   = 1'b1;
                            last_unit_s   = cand_v;
                        end else begin
                            found_v = found_v;
                        end
                    end
                end
            end
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Next round-robin start: one past the last unit granted this cycle.
    always_comb begin
        logic [UNIT_W:0] nsum_v;
        nsum_v = {1'b0, last_unit_s} + (UNIT_W+1)'(1);
        if (nsum_v >= (UNIT_W+1)'(NUM_WB_UNITS)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = nsum_v[UNIT_W-1:0];
        end
    end

    // Round-robin pointer; holds when nothing was arbitrated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else if (grant_any_s) begin
            rr_ptr_r <= next_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Commit qualification: only the newest ID for a register writes, never x0, and a
    // lower port already writing the same register wins. Stale results are still acked.
    always_comb begin
        update_s = '0;
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            update_s[p] = retired_s[p] && (rd_addr[p] != '0)
                          && ((FIXED_PORT0 && (p == 0)) || (id_for_rd[p] == ids_s[p]));
            for (int q = 0; q < p; q++) begin
                if (update_s[q] && (rd_addr[q] == rd_addr[p])) begin
                    update_s[p] = 1'b0;
                end else begin
                    update_s[p] = update_s[p];
                end
            end
        end
    end

    // Live-value table: remembers which bank holds each register's newest value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                lvt_r[i] <= '0;
            end
        end else begin
            for (int p = 0; p < COMMIT_PORTS; p++) begin
                if (update_s[p]) begin
                    lvt_r[rd_addr[p]] <= LVT_W'(p);
                end
            end
        end
    end

    for (genvar g = 0; g < COMMIT_PORTS; g++) begin : g_bank
        regfile_bank #(
            .XLEN       (XLEN),
            .NUM_REGS   (NUM_REGS),
            .READ_PORTS (READ_PORTS)
        ) u_bank (
            .clk   (clk),
            .we    (update_s[g]),
            .waddr (rd_addr[g]),
            .wdata (cdata_s[g]),
            .raddr (rs_addr),
            .rdata (bank_rd_s[g])
        );
    end

    // Read steering through the LVT, with optional same-cycle bypass (lowest port wins).
    always_comb begin
        logic hit_v;
        rs_data_s = '0;
        hit_v     = 1'b0;
        for (int r = 0; r < READ_PORTS; r++) begin
            hit_v = 1'b0;
            if (rs_addr[r] == '0) begin
                rs_data_s[r] = '0;
            end else begin
                for (int p = 0; p < COMMIT_PORTS; p++) begin
                    if (lvt_r[rs_addr[r]] == LVT_W'(p)) begin
                        rs_data_s[r] = bank_rd_s[p][r];
                    end else begin
                        rs_data_s[r] = rs_data_s[r];
                    end
                end
                if (BYPASS) begin
                    for (int p = 0; p < COMMIT_PORTS; p++) begin
                        if (!hit_v && update_s[p] && (rd_addr[p] == rs_addr[r])) begin
                            hit_v        = 1'b1;
                            rs_data_s[r] = cdata_s[p];
                        end else begin
                            hit_v = hit_v;
                        end
                    end
                end else begin
                    hit_v = 1'b0;
                end
            end
        end
    end

    // Store-forward match: lowest retiring port carrying the awaited ID.
    always_comb begin
        st_match_s = 1'b0;
        st_cap_s   = '0;
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            if (!st_match_s && st_waiting && retired_s[p] && (ids_s[p] == st_id)) begin
                st_match_s = 1'b1;
                st_cap_s   = cdata_s[p];
            end else begin
                st_match_s = st_match_s;
            end
        end
    end

    // Store-forward capture; a new match takes precedence over st_ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_done_r <= 1'b0;
            st_data_r <= '0;
        end else if (st_match_s) begin
            st_done_r <= 1'b1;
            st_data_r <= st_cap_s;
        end else if (st_ack) begin
            st_done_r <= 1'b0;
        end else begin
            st_done_r <= st_done_r;
        end
    end

    assign wb.unit_ack    = ack_s;
    assign retired        = retired_s;
    assign ids_retiring   = ids_s;
    assign rs_data        = rs_data_s;
    assign st_done        = st_done_r;
    assign st_data        = st_data_r;

endmodule
